// File: rtl/icmp_echo_responder.sv
// rtl/icmp_echo_responder.sv - ICMP echo responder: captures echo requests and replays them as echo replies
//
// Ports:
//   clk, reset_n           clock and synchronous active-low reset
//   rx_head, rx_newhead    inbound ICMP header and its one-cycle valid strobe
//   rx_data, rx_dven       inbound payload byte stream (contiguous run)
//   rx_error               upstream error flag, sampled throughout the frame
//   tx_head                reply header, held from request until DONE
//   tx_data, tx_dven       reply payload byte stream (gap-free)
//   request, ack           frame-slot handshake with the transmit path
//   busy                   high whenever the responder is not idle
//   reply_cnt, drop_cnt    wrapping counters of replies sent / requests dropped
module icmp_echo_responder #(
  parameter int AW         = 9,
  parameter int ACKTIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] rx_head,
  input  logic        rx_newhead,
  input  logic [7:0]  rx_data,
  input  logic        rx_dven,
  input  logic        rx_error,
  output logic [63:0] tx_head,
  output logic [7:0]  tx_data,
  output logic        tx_dven,
  output logic        request,
  input  logic        ack,
  output logic        busy,
  output logic [15:0] reply_cnt,
  output logic [15:0] drop_cnt
);

  localparam int DEPTH = 1 << AW;
  localparam int TW    = $clog2(ACKTIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_REQ     = 3'd2;
  localparam logic [2:0] S_WAITACK = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [15:0]   ECHO_REQ = 16'h0800;
  localparam logic [AW:0]   FULL     = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   ONE      = {{AW{1'b0}}, 1'b1};
  localparam logic [TW-1:0] TO_LAST  = TW'(ACKTIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [15:0]   chk_in_q, chk_in_d;
  logic [31:0]   rest_q, rest_d;
  // wcnt doubles as the payload length once capture has finished
  logic [AW:0]   wcnt_q, wcnt_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic [AW:0]   rptr_q, rptr_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [63:0]   tx_head_q, tx_head_d;
  logic [15:0]   reply_q, reply_d;
  logic [15:0]   drop_q, drop_d;
  logic [1:0]    drop_inc;

  logic [7:0]    mem [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_q;

  logic          is_echo;
  logic [16:0]   chk_sum;
  logic [15:0]   chk_out;
  logic [AW:0]   wcnt_nxt;
  logic [AW:0]   rptr_nxt;

  assign is_echo  = rx_newhead && (rx_head[63:48] == ECHO_REQ);
  assign wcnt_nxt = wcnt_q + ONE;
  assign rptr_nxt = rptr_q + ONE;

  // Type 8 -> 0 lowers the first header word by 0x0800, so the one's
  // complement checksum rises by 0x0800 with end-around carry. The carry
  // add cannot itself overflow, and 0xFFFF is deliberately not folded.
  assign chk_sum = {1'b0, chk_in_q} + {1'b0, ECHO_REQ};
  assign chk_out = chk_sum[15:0] + {15'd0, chk_sum[16]};

  always_comb begin
    state_d   = state_q;
    chk_in_d  = chk_in_q;
    rest_d    = rest_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    rptr_d    = rptr_q;
    tcnt_d    = tcnt_q;
    tx_head_d = tx_head_q;
    reply_d   = reply_q;
    drop_inc  = 2'd0;
    wr_en     = 1'b0;
    wr_addr   = wcnt_q[AW-1:0];
    rd_addr   = '0;

    case (state_q)
      S_IDLE: begin
        if (is_echo) begin
          chk_in_d = rx_head[47:32];
          rest_d   = rx_head[31:0];
          err_d    = rx_error;
          ovf_d    = 1'b0;
          wcnt_d   = '0;
          state_d  = S_CAPTURE;
          // a byte coincident with the header strobe is the first payload byte
          if (rx_dven) begin
            wr_en   = 1'b1;
            wr_addr = '0;
            wcnt_d  = ONE;
          end
        end
      end

      S_CAPTURE: begin
        if (rx_dven) begin
          err_d = err_q | rx_error;
          if (wcnt_q == FULL) begin
            ovf_d = 1'b1;
          end else begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_nxt;
          end
        end else if (err_q || rx_error || ovf_q) begin
          drop_inc = 2'd1;
          state_d  = S_IDLE;
        end else begin
          tx_head_d = {8'h00, 8'h00, chk_out, rest_q};
          state_d   = S_REQ;
        end
      end

      S_REQ: begin
        tcnt_d  = '0;
        state_d = S_WAITACK;
      end

      S_WAITACK: begin
        // address 0 goes out in the ack cycle so byte 0 is ready for SEND
        rd_addr = '0;
        rptr_d  = '0;
        if (ack) begin
          state_d = S_SEND;
        end else if (tcnt_q == TO_LAST) begin
          drop_inc = 2'd1;
          state_d  = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_SEND: begin
        // prefetch the next byte every cycle to keep tx_dven gap-free
        rd_addr = rptr_nxt[AW-1:0];
        rptr_d  = rptr_nxt;
        if ((wcnt_q == '0) || (rptr_nxt == wcnt_q)) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        reply_d = reply_q + 16'd1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // an echo request arriving while a reply is pending is refused; this
    // can coincide with an ack timeout, hence the two-bit increment
    if (is_echo && (state_q >= S_REQ) && (state_q <= S_DONE)) begin
      drop_inc = drop_inc + 2'd1;
    end
  end

  assign drop_d = drop_q + {14'd0, drop_inc};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      chk_in_q  <= '0;
      rest_q    <= '0;
      wcnt_q    <= '0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      rptr_q    <= '0;
      tcnt_q    <= '0;
      tx_head_q <= '0;
      reply_q   <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      chk_in_q  <= chk_in_d;
      rest_q    <= rest_d;
      wcnt_q    <= wcnt_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      rptr_q    <= rptr_d;
      tcnt_q    <= tcnt_d;
      tx_head_q <= tx_head_d;
      reply_q   <= reply_d;
      drop_q    <= drop_d;
    end
  end

  // payload buffer: plain synchronous RAM, one-cycle read latency
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= rx_data;
    end
    rd_q <= mem[rd_addr];
  end

  assign tx_head   = tx_head_q;
  assign tx_dven   = (state_q == S_SEND) && (wcnt_q != '0);
  assign tx_data   = tx_dven ? rd_q : 8'h00;
  assign request   = (state_q == S_REQ);
  assign busy      = (state_q != S_IDLE);
  assign reply_cnt = reply_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_icmp_echo_responder.sv
// tb/tb_icmp_echo_responder.sv - self-checking bench for icmp_echo_responder
module tb_icmp_echo_responder;

  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;
  localparam int TO    = 20;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] rx_head = '0;
  logic        rx_newhead = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_dven = 1'b0;
  logic        rx_error = 1'b0;
  logic [63:0] tx_head;
  logic [7:0]  tx_data;
  logic        tx_dven;
  logic        request;
  logic        ack = 1'b0;
  logic        busy;
  logic [15:0] reply_cnt;
  logic [15:0] drop_cnt;

  always #5 clk = ~clk;

  icmp_echo_responder #(.AW(AW), .ACKTIMEOUT(TO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_head    (rx_head),
    .rx_newhead (rx_newhead),
    .rx_data    (rx_data),
    .rx_dven    (rx_dven),
    .rx_error   (rx_error),
    .tx_head    (tx_head),
    .tx_data    (tx_data),
    .tx_dven    (tx_dven),
    .request    (request),
    .ack        (ack),
    .busy       (busy),
    .reply_cnt  (reply_cnt),
    .drop_cnt   (drop_cnt)
  );

  int passed = 0;
  int total  = 0;
  int exp_reply = 0;
  int exp_drop  = 0;
  logic [7:0] pay [DEPTH + 8];

  // output monitor, sampled on the falling edge
  int         cyc = 0;
  logic [7:0] got [$];
  int         req_seen = 0;
  int         runs = 0;
  int         first_cyc = 0;
  int         ack_cyc = 0;
  int         nz_err = 0;
  logic [63:0] head_at_req = '0;
  logic       prev_dven = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (request) begin
      req_seen    <= req_seen + 1;
      head_at_req <= tx_head;
    end
    if (ack) ack_cyc <= cyc;
    if (tx_dven) begin
      got.push_back(tx_data);
      if (!prev_dven) begin
        runs      <= runs + 1;
        first_cyc <= cyc;
      end
    end else if (tx_data != 8'h00) begin
      nz_err <= nz_err + 1;
    end
    prev_dven <= tx_dven;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // reply header from the one's complement rule, independent of bit-level carries
  function automatic logic [63:0] model_head(input logic [63:0] hd);
    int s;
    s = int'(hd[47:32]) + 32'h0800;
    if (s > 32'hFFFF) s = s - 32'hFFFF;
    return {16'h0000, s[15:0], hd[31:0]};
  endfunction

  task automatic send_frame(input logic [63:0] hd, input int n, input int err_idx);
    rx_head = hd;
    rx_newhead = 1'b1;
    tick();
    rx_newhead = 1'b0;
    for (int i = 0; i < n; i++) begin
      rx_dven  = 1'b1;
      rx_data  = pay[i];
      rx_error = (i == err_idx);
      tick();
    end
    rx_dven  = 1'b0;
    rx_data  = 8'h00;
    rx_error = 1'b0;
    tick();
  endtask

  task automatic run_frame(input logic [63:0] hd, input int n, input int err_idx,
                           input int ack_d, input logic exp_req, input logic [63:0] exp_head);
    int r0, g0, u0, t, bad;
    r0 = req_seen;
    g0 = got.size();
    u0 = runs;
    send_frame(hd, n, err_idx);
    if (exp_req) exp_reply++;
    else if (hd[63:48] == 16'h0800) exp_drop++;
    if (exp_req) begin
      t = 0;
      while (!request && t < 4) begin tick(); t++; end
      repeat (ack_d) tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      t = 0;
      while (busy && t < DEPTH + 8) begin tick(); t++; end
    end else begin
      repeat (3) tick();
    end
    tick();
    chk("req_pulses", req_seen - r0, exp_req ? 1 : 0);
    chk("busy_end", busy, 0);
    chk("reply_cnt", reply_cnt, exp_reply);
    chk("drop_cnt", drop_cnt, exp_drop);
    if (exp_req) begin
      chk("tx_head", head_at_req, exp_head);
      chk("byte_count", got.size() - g0, n);
      bad = 0;
      for (int i = 0; i < n; i++)
        if (got.size() <= g0 + i || got[g0 + i] !== pay[i]) bad++;
      chk("payload_bytes_wrong", bad, 0);
      chk("dven_runs", runs - u0, n > 0 ? 1 : 0);
      if (n > 0) chk("dven_start_after_ack", first_cyc - ack_cyc, 1);
    end
  endtask

  typedef struct {
    logic [63:0] hd;
    int          n;
    int          err;
    int          ack_d;
    logic        exp_req;
    logic [63:0] exp_head;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [63:0] hd;
    int n, err, ack_d, sel, r0, g0, bad;
    logic expq;

    vt[0] = '{64'h0800_1234_ABCD_0001, 4,         -1, 3, 1'b1, 64'h0000_1A34_ABCD_0001};
    vt[1] = '{64'h0800_F900_0000_0002, 2,         -1, 1, 1'b1, 64'h0000_0101_0000_0002};
    vt[2] = '{64'h0800_F7FF_1111_2222, 3,         -1, 2, 1'b1, 64'h0000_FFFF_1111_2222};
    vt[3] = '{64'h0800_0000_5555_6666, 0,         -1, 2, 1'b1, 64'h0000_0800_5555_6666};
    vt[4] = '{64'h0000_1234_0000_0000, 3,         -1, 1, 1'b0, 64'h0};
    vt[5] = '{64'h0801_1234_0000_0000, 3,         -1, 1, 1'b0, 64'h0};
    vt[6] = '{64'h0800_1234_0000_0007, 5,          2, 1, 1'b0, 64'h0};
    vt[7] = '{64'h0800_1234_0000_0008, DEPTH + 1, -1, 1, 1'b0, 64'h0};
    vt[8] = '{64'h0800_FFFF_7777_8888, DEPTH,     -1, 1, 1'b1, 64'h0000_0800_7777_8888};

    repeat (3) tick();
    chk("rst_tx_head", tx_head, 0);
    chk("rst_tx_dven", tx_dven, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_request", request, 0);
    chk("rst_busy", busy, 0);
    chk("rst_reply_cnt", reply_cnt, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset_n = 1'b1;
    tick();

    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < DEPTH + 8; i++) pay[i] = 8'(i + 1);
      run_frame(vt[v].hd, vt[v].n, vt[v].err, vt[v].ack_d, vt[v].exp_req, vt[v].exp_head);
    end

    // second echo request while waiting for ack: refused, first reply intact
    pay[0] = 8'hA1; pay[1] = 8'hA2; pay[2] = 8'hA3;
    r0 = req_seen;
    g0 = got.size();
    send_frame(64'h0800_3000_0A0A_0B0B, 3, -1);
    tick();
    rx_head = 64'h0800_4444_0C0C_0D0D;
    rx_newhead = 1'b1;
    tick();
    rx_newhead = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_dven = 1'b1;
      rx_data = 8'(8'hE0 + i);
      tick();
    end
    rx_dven = 1'b0;
    rx_data = 8'h00;
    tick();
    exp_drop++;
    chk("busy_in_waitack", busy, 1);
    chk("busy_drop_cnt", drop_cnt, exp_drop);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int t = 0; t < 12 && busy; t++) tick();
    tick();
    exp_reply++;
    chk("busy_req_pulses", req_seen - r0, 1);
    chk("busy_tx_head", head_at_req, 64'h0000_3800_0A0A_0B0B);
    chk("busy_tx_head_held", tx_head, 64'h0000_3800_0A0A_0B0B);
    bad = 0;
    for (int i = 0; i < 3; i++)
      if (got.size() <= g0 + i || got[g0 + i] !== pay[i]) bad++;
    chk("busy_payload_bytes_wrong", bad, 0);
    chk("busy_byte_count", got.size() - g0, 3);
    chk("busy_reply_cnt", reply_cnt, exp_reply);

    // ack timeout: WAITACK lasts exactly TO cycles
    g0 = got.size();
    send_frame(64'h0800_0101_0202_0303, 2, -1);
    chk("to_request", request, 1);
    repeat (TO) tick();
    chk("to_busy_last_cycle", busy, 1);
    tick();
    chk("to_idle", busy, 0);
    exp_drop++;
    chk("to_drop_cnt", drop_cnt, exp_drop);
    chk("to_reply_cnt", reply_cnt, exp_reply);
    chk("to_no_bytes", got.size() - g0, 0);
    for (int i = 0; i < 4; i++) pay[i] = 8'(8'h50 + i);
    run_frame(64'h0800_1000_AAAA_BBBB, 4, -1, 2, 1'b1, 64'h0000_1800_AAAA_BBBB);

    // reset in the middle of SEND
    for (int i = 0; i < 6; i++) pay[i] = 8'(8'h70 + i);
    send_frame(64'h0800_2000_1212_3434, 6, -1);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    reset_n = 1'b0;
    tick();
    chk("rstsend_tx_dven", tx_dven, 0);
    chk("rstsend_tx_data", tx_data, 0);
    chk("rstsend_busy", busy, 0);
    chk("rstsend_reply_cnt", reply_cnt, 0);
    chk("rstsend_drop_cnt", drop_cnt, 0);
    chk("rstsend_tx_head", tx_head, 0);
    reset_n = 1'b1;
    exp_reply = 0;
    exp_drop = 0;
    tick();
    for (int i = 0; i < 5; i++) pay[i] = 8'(8'h90 + i);
    run_frame(64'h0800_3333_4444_5555, 5, -1, 1, 1'b1, 64'h0000_3B33_4444_5555);

    // randomized frames against the reference model
    for (int k = 0; k < 20; k++) begin
      sel = int'($urandom_range(0, 9));
      hd = {16'h0800, 16'($urandom), 32'($urandom)};
      if (sel == 0) hd[63:48] = 16'h0000;
      else if (sel == 1) hd[63:48] = 16'h0801;
      n = int'($urandom_range(0, DEPTH));
      if (sel == 2) n = DEPTH + 1;
      err = -1;
      if (sel == 3 && n > 0) err = int'($urandom_range(0, n - 1));
      ack_d = int'($urandom_range(1, 6));
      for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
      expq = (hd[63:48] == 16'h0800) && (err < 0) && (n <= DEPTH);
      run_frame(hd, n, err, ack_d, expq, model_head(hd));
    end

    chk("tx_data_nonzero_while_idle", nz_err, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icmp_echo_responder.md
Name: icmp_echo_responder

Overview:
- ICMP client that sits on the application side of the ICMP-over-IPv4 link.
- Captures inbound ICMP echo requests (type 8, code 0): header on the rx head strobe, payload from the rx byte stream, payload stored in a local buffer.
- For each accepted request it issues a transmit request, waits for the grant, then drives the echo reply: type 0, code 0, incrementally corrected checksum, identifier/sequence copied, payload replayed.
- It is the responder for the ICMP receive path and the data source for the ICMP transmit path.

Parameters:
- AW, 9: payload buffer address width; the buffer holds 2**AW bytes.
- ACKTIMEOUT, 1024: cycles to wait for ack before abandoning a reply.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  synchronous, active-low reset.
- rx_head  input  64  ICMP header {type,code,checksum,restofheader}; valid when rx_newhead=1.
- rx_newhead  input  1  one-cycle strobe marking header valid and the start of the payload.
- rx_data  input  8  payload byte.
- rx_dven  input  1  payload byte valid; contiguous run, frame ends on its falling edge.
- rx_error  input  1  upstream error flag; sampled throughout the frame.
- tx_head  output  64  reply header; held stable from request until DONE.
- tx_data  output  8  reply payload byte.
- tx_dven  output  1  reply payload byte valid.
- request  output  1  one-cycle pulse asking the transmit path for a frame slot.
- ack  input  1  grant from the transmit path.
- busy  output  1  high while not IDLE.
- reply_cnt  output  16  replies sent; wraps.
- drop_cnt  output  16  requests dropped; wraps.

Behaviour:
- Reset values: every output is 0, the state is IDLE, and both counters are 0. A reset asserted mid-frame abandons the frame immediately; it does not increment drop_cnt.
- State machine: IDLE, CAPTURE, REQ, WAITACK, SEND, DONE.
- IDLE -> CAPTURE on rx_newhead when rx_head[63:48]==16'h0800.
  - Capture rx_head[47:32] as chk_in and rx_head[31:0] as rest.
  - Clear the byte count wcnt and the error flag.
  - rx_newhead with any other type/code is ignored and not counted.
- CAPTURE:
  - Each rx_dven cycle writes rx_data at address wcnt, then wcnt++.
  - rx_error at any cycle sets the error flag.
  - A write when wcnt==2**AW sets an overflow flag instead of writing.
  - On the first cycle with rx_dven=0 after at least one byte: if error or overflow, drop_cnt++ and go to IDLE; otherwise go to REQ.
  - A zero-length payload (no rx_dven before the next rx_newhead or any idle cycle) goes to REQ with len=0.
- Checksum (registered on entry to REQ):
  - chk_out = chk_in + 16'h0800 with end-around carry.
  - If the 17-bit sum carries, add 1. A result of 16'hFFFF is kept as-is (no zero folding).
  - tx_head = {8'h00, 8'h00, chk_out, rest}.
- REQ: request=1 for exactly one cycle, then go to WAITACK.
- WAITACK:
  - On ack=1, go to SEND the next cycle.
  - After ACKTIMEOUT cycles without ack, drop_cnt++ and go to IDLE.
- SEND:
  - Starts the cycle after ack.
  - Presents buffer bytes 0..len-1 on consecutive cycles with tx_dven=1; no gaps are allowed, because the downstream FIFO treats any gap as end of frame.
  - Buffer read latency is 1 cycle: the read address is issued in the ack cycle.
  - len=0: no data cycles.
  - Then go to DONE.
- DONE: tx_dven=0 and tx_data=0; reply_cnt++; go to IDLE in the next cycle.
- rx_newhead while busy (REQ..DONE): the request is ignored and drop_cnt++. The stored payload and tx_head are unchanged.
- tx_data is 0 whenever tx_dven=0.

Test Plan:
- Echo request, header 64'h0800_1234_ABCD_0001, 4 payload bytes 01 02 03 04, ack 3 cycles after request:
  - request pulses once; tx_head=64'h0000_1A34_ABCD_0001.
  - tx_dven high for exactly 4 consecutive cycles starting the cycle after ack, with tx_data 01,02,03,04; reply_cnt=1.
- Checksum wrap, chk_in=16'hF900 -> chk_out=16'h0101. Checksum at the boundary, chk_in=16'hF7FF -> chk_out=16'hFFFF.
- rx_error pulsed mid-payload -> no request pulse; drop_cnt=1. Payload of 2**AW+1 bytes -> dropped; drop_cnt increments.
- Header type 0 or code 1 -> ignored, no request, counters unchanged. Second echo request arriving during WAITACK -> drop_cnt++; the first reply is sent with its own payload intact.
- No ack for ACKTIMEOUT cycles -> back to IDLE, drop_cnt++; a subsequent request with ack is serviced normally.
- reset_n low during SEND -> the next cycle has tx_dven=0, busy=0, counters 0; a following echo request works normally.
